msg_fifo_sync: RTL and testbench
================================

// Module: msg_fifo_sync
// PURPOSE
//   Synchronous, parametrised message FIFO; successor to the edge-triggered message queue.
//   Single clock, valid/ready handshake on both sides, first-word-fall-through read.
//   Adds occupancy count, almost-full threshold, synchronous flush and sticky overflow flag.
//   Sits between message producers (e.g. board/cell update logic) and consumers.
// PARAMETERS
//   MSG_WIDTH  24   bits per message
//   DEPTH      100  number of entries; any value >= 2, not necessarily a power of 2
//   AF_LEVEL   96   almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
//   CW         $clog2(DEPTH+1)  count width (localparam, not overridable)
// PORTS
//   clock        in   1          rising-edge clock
//   reset_n      in   1          asynchronous, active-low reset
//   flush        in   1          synchronous clear of all contents
//   wr_valid     in   1          producer offers wr_data
//   wr_ready     out  1          FIFO can accept a message this cycle
//   wr_data      in   MSG_WIDTH  message to enqueue
//   rd_valid     out  1          rd_data holds the oldest message
//   rd_ready     in   1          consumer takes rd_data this cycle
//   rd_data      out  MSG_WIDTH  oldest message (head of queue)
//   count        out  CW         current occupancy, 0..DEPTH
//   almost_full  out  1          count >= AF_LEVEL
//   overflow     out  1          sticky: write attempted while full
// BEHAVIOUR
// - Reset (reset_n low, async):
//   - wr_ptr = rd_ptr = 0, count = 0, overflow = 0.
//   - Outputs: rd_valid = 0, wr_ready = 1, almost_full = 0.
//   - Storage array is not reset.
// - Control flags: wr_ready = (count != DEPTH); rd_valid = (count != 0).
//   - Both decode only registered state; no combinational path from rd_ready to wr_ready.
// - Push = wr_valid & wr_ready.
//   - mem[wr_ptr] <= wr_data; wr_ptr advances.
// - Pop = rd_valid & rd_ready.
//   - rd_ptr advances.
// - rd_data = mem[rd_ptr] (FWFT).
//   - Content is undefined while rd_valid = 0.
//   - Content is stable while rd_valid & !rd_ready.
// - Latency: a push into an empty FIFO at edge N gives rd_valid = 1 and rd_data = that word after edge N.
//   - No same-cycle pass-through.
// - Pointer wrap: pointer == DEPTH-1 -> 0 on advance.
//   - Explicit compare; no modulo and no reliance on a power-of-2 DEPTH.
// - count: +1 on push only; -1 on pop only; unchanged on simultaneous push+pop.
// - Full FIFO with pop and wr_valid in the same cycle: wr_ready is 0, so the push is rejected.
//   - Pop completes; count = DEPTH-1 next cycle.
// - Empty FIFO with rd_ready and no push: no effect, no error.
// - overflow is set when wr_valid & !wr_ready & !flush.
//   - Stays set until flush or reset.
// - flush (highest priority after reset):
//   - Next cycle: pointers = 0, count = 0, overflow = 0.
//   - Any push or pop in the flush cycle is discarded.
// - almost_full is registered alongside count.
//   - It reflects the count it is registered with, with no extra cycle of lag.
// - Ordering: strict FIFO. No message is lost or duplicated except by flush or reset.
// TESTING (MSG_WIDTH=8, DEPTH=5, AF_LEVEL=4)
// - Reset then idle: rd_valid=0, wr_ready=1, count=0, almost_full=0, overflow=0.
// - Push 0x11,0x22,0x33 on back-to-back cycles, rd_ready=0:
//   - rd_valid=1 with rd_data=0x11 after the first edge; count=3.
//   - Then pops return 0x11,0x22,0x33 in order.
// - Fill to 5 (almost_full=1 at count 4, wr_ready=0 at 5); push 0x99 -> rejected, overflow=1.
//   - Drain returns the original 5 messages.
// - Fill to full, assert pop and wr_valid in the same cycle -> count=4, new word not stored.
//   - Then push+pop together for 7 cycles: count stays 4, pointers wrap, order preserved.
// - Mid-traffic flush with wr_valid=1 and rd_ready=1:
//   - count=0, rd_valid=0, overflow=0 next cycle; the flushed-cycle word never appears.
// - Assert reset_n low asynchronously mid-burst at count=3:
//   - Outputs reach reset values before the next clock edge.
//   - Normal operation resumes after reset_n is released.

Source files
------------

// File: rtl/msg_fifo_sync.sv
// -----------------------------------------------------------------------------
// msg_fifo_sync
//   Single-clock message FIFO with valid/ready handshakes on both sides and a
//   first-word-fall-through read port. Tracks occupancy, raises a registered
//   almost-full flag at a programmable threshold, supports a synchronous flush
//   and latches a sticky overflow flag when a producer offers data while full.
//
//   DEPTH need not be a power of two: pointers wrap by explicit compare.
//
// Ports
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   flush        in   synchronous clear of all contents (beats push/pop)
//   wr_valid     in   producer offers wr_data
//   wr_ready     out  FIFO can accept a message this cycle
//   wr_data      in   message to enqueue
//   rd_valid     out  rd_data holds the oldest message
//   rd_ready     in   consumer takes rd_data this cycle
//   rd_data      out  oldest message (head of queue)
//   count        out  current occupancy, 0..DEPTH
//   almost_full  out  count >= AF_LEVEL
//   overflow     out  sticky: write attempted while full
// -----------------------------------------------------------------------------
module msg_fifo_sync #(
  parameter  int unsigned MSG_WIDTH = 24,
  parameter  int unsigned DEPTH     = 100,
  parameter  int unsigned AF_LEVEL  = 96,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [MSG_WIDTH-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [MSG_WIDTH-1:0] rd_data,
  output logic [CW-1:0]        count,
  output logic                 almost_full,
  output logic                 overflow
);

  localparam int unsigned     PW     = $clog2(DEPTH);
  localparam logic [CW-1:0]   FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0]   AF_C   = CW'(AF_LEVEL);
  localparam logic [PW-1:0]   LAST_C = PW'(DEPTH - 1);

  // Elaboration-time guards on parameter legality.
  if (DEPTH < 2) begin : g_bad_depth
    $error("msg_fifo_sync: DEPTH must be >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("msg_fifo_sync: AF_LEVEL must be in 1..DEPTH");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [MSG_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_almost_full;
  logic                 r_overflow;

  // ---------------------------------------------------------------------------
  // Handshake decode: both flags come straight from the registered count, so
  // there is no combinational path from rd_ready to wr_ready. A full FIFO
  // therefore refuses a write even when a pop happens in the same cycle.
  // ---------------------------------------------------------------------------
  logic w_wr_ready;
  logic w_rd_valid;
  logic w_push;
  logic w_pop;

  assign w_wr_ready = (r_count != FULL_C);
  assign w_rd_valid = (r_count != '0);

  // Flush discards any handshake that happens to complete in its cycle.
  assign w_push = wr_valid & w_wr_ready & ~flush;
  assign w_pop  = w_rd_valid & rd_ready & ~flush;

  // ---------------------------------------------------------------------------
  // Next-state computation
  // ---------------------------------------------------------------------------
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_overflow_nxt;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;

    if (flush) begin
      w_wr_ptr_nxt   = '0;
      w_rd_ptr_nxt   = '0;
      w_count_nxt    = '0;
      w_overflow_nxt = 1'b0;
    end else begin
      // Explicit wrap compare keeps non-power-of-2 depths correct.
      if (w_push) begin
        w_wr_ptr_nxt = (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + PW'(1);
      end

      unique case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase

      if (wr_valid && !w_wr_ready) begin
        w_overflow_nxt = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers. almost_full is computed from the next count so it is
  // registered together with the count it describes, with no extra lag.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_count       <= w_count_nxt;
      r_almost_full <= (w_count_nxt >= AF_C);
      r_overflow    <= w_overflow_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; contents are only observable once
  // count says they are valid, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wr_ready    = w_wr_ready;
  assign rd_valid    = w_rd_valid;
  assign rd_data     = r_mem[r_rd_ptr];  // FWFT head; undefined while empty
  assign count       = r_count;
  assign almost_full = r_almost_full;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_msg_fifo_sync.sv
// -----------------------------------------------------------------------------
// tb_msg_fifo_sync
//   Self-checking bench for msg_fifo_sync with MSG_WIDTH=8, DEPTH=5, AF_LEVEL=4.
//   A reference queue holds every accepted word; pops observed on the DUT are
//   compared against the head of that queue.
// -----------------------------------------------------------------------------
module tb_msg_fifo_sync;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 5;
  localparam int unsigned AF = 4;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clock = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [W-1:0]  wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [W-1:0] sb_q[$];
  logic         m_ovf;

  msg_fifo_sync #(.MSG_WIDTH(W), .DEPTH(D), .AF_LEVEL(AF)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  // One clock cycle of stimulus. Called at posedge+1, returns at posedge+1.
  // Maintains the scoreboard and compares every popped word against it.
  task automatic step(input logic wv, input logic [W-1:0] wd,
                      input logic rr, input logic fl);
    logic m_full;
    logic m_empty;
    logic [W-1:0] exp_d;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    #1;
    m_full  = (sb_q.size() == D);
    m_empty = (sb_q.size() == 0);
    n_cmp++;
    if (wr_ready !== !m_full) begin
      n_bad++;
      $display("FAIL wr_ready: got %b expected %b", wr_ready, !m_full);
    end
    n_cmp++;
    if (rd_valid !== !m_empty) begin
      n_bad++;
      $display("FAIL rd_valid: got %b expected %b", rd_valid, !m_empty);
    end
    if (fl) begin
      sb_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (rr && !m_empty) begin
        exp_d = sb_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_d) begin
          n_bad++;
          $display("FAIL pop_data: got %02h expected %02h", rd_data, exp_d);
        end
      end
      if (wv && !m_full) sb_q.push_back(wd);
      if (wv && m_full)  m_ovf = 1'b1;
    end
    @(posedge clock);
    #1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
  endtask

  // Compare registered status against the model after a step.
  task automatic check_status(input string tag);
    n_cmp++;
    if (count !== CW'(sb_q.size())) begin
      n_bad++;
      $display("FAIL %s count: got %0d expected %0d", tag, count, sb_q.size());
    end
    n_cmp++;
    if (almost_full !== (sb_q.size() >= AF)) begin
      n_bad++;
      $display("FAIL %s almost_full: got %b expected %b", tag, almost_full,
               (sb_q.size() >= AF));
    end
    n_cmp++;
    if (overflow !== m_ovf) begin
      n_bad++;
      $display("FAIL %s overflow: got %b expected %b", tag, overflow, m_ovf);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    wr_data  = '0;
    m_ovf    = 1'b0;
    sb_q.delete();
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset rd_valid: got %b expected 0", rd_valid);
    end
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset wr_ready: got %b expected 1", wr_ready);
    end
    check_status("reset");
  endtask

  task automatic test_basic();
    logic [W-1:0] first;
    step(1'b1, 8'h11, 1'b0, 1'b0);
    first = 8'h11;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== first) begin
      n_bad++;
      $display("FAIL fwft_head: got v=%b d=%02h expected v=1 d=%02h",
               rd_valid, rd_data, first);
    end
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    check_status("basic_fill");
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    check_status("basic_drain");
  endtask

  task automatic test_empty_pop();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_status("empty_pop");
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, W'(8'hA1 + i), 1'b0, 1'b0);
      check_status($sformatf("fill%0d", i + 1));
    end
    step(1'b1, 8'h99, 1'b0, 1'b0);
    check_status("overflow_set");
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    check_status("overflow_drain");
    step(1'b0, '0, 1'b0, 1'b1);
    check_status("overflow_flush");
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'hB1 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    check_status("full_pushpop");
    for (int i = 0; i < 7; i++) begin
      step(1'b1, W'(8'hC0 + i), 1'b1, 1'b0);
      check_status($sformatf("steady%0d", i));
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    check_status("steady_drain");
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b1, 1'b0);
    step(1'b1, 8'h43, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush rd_valid: got %b expected 0", rd_valid);
    end
    check_status("flush");
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_status("post_flush");
  endtask

  task automatic test_async_reset();
    step(1'b1, 8'h61, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0);
    wr_valid = 1'b1;
    wr_data  = 8'h63;
    rd_ready = 1'b0;
    @(posedge clock);
    #2;
    sb_q.delete();
    m_ovf = 1'b0;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset flags: got rv=%b wr=%b expected rv=0 wr=1",
               rd_valid, wr_ready);
    end
    check_status("async_reset");
    wr_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    step(1'b1, 8'h71, 1'b0, 1'b0);
    step(1'b1, 8'h72, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_status("resume");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_pop();
    test_full_overflow();
    test_full_push_pop();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
